vid_pix_drain: RTL and testbench

Read-side consumer of the `vid_pix_fifo` pixel FIFO, in the FIFO read clock domain. It pulls 32-bit pixel words from the FIFO's first-word-fall-through read port and writes them to external frame memory as fixed-length write bursts at linearly incrementing addresses. When the memory controller aborts a burst, the block uses the FIFO rewind port to replay every word it popped, then retries the burst at the same address, so no pixels are lost.

---
 rtl/vid_pix_pkg.sv | 26 ++
 rtl/vid_pix_drain.sv | 166 ++++++++++++++++
 tb/tb_vid_pix_drain.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/vid_pix_pkg.sv
// Shared constants and types for the video pixel FIFO and its read-side drain.
// Holds the drain state encoding, the rewind-count width and FIFO geometry.
package vid_pix_pkg;

    localparam int PIX_W      = 32;
    localparam int RWD_W      = 5;
    localparam int FIFO_AW    = 10;
    localparam int FIFO_DEPTH = 1024;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_DATA = 3'd2,
        ST_WAIT = 3'd3,
        ST_RWD  = 3'd4
    } drain_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/vid_pix_drain.sv
// Drains the pixel FIFO into frame memory as fixed-length write bursts,
// rewinding the FIFO and retrying at the same address when a burst aborts.
module vid_pix_drain
    import vid_pix_pkg::*;
#(
    parameter int BURST_LEN   = 16,
    parameter int ADDR_WIDTH  = 24,
    parameter int FRAME_WORDS = 76800
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PIX_W-1:0]      f_data,
    output logic                  f_ena,
    input  logic                  f_aempty,
    input  logic                  f_empty,
    output logic [RWD_W-1:0]      f_rwd_words,
    output logic                  f_rwd_stb,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [RWD_W-1:0]      m_len,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [PIX_W-1:0]      m_wdata,
    input  logic                  m_wnext,
    input  logic                  m_done,
    input  logic                  m_abort,
    input  logic                  ctl_run,
    input  logic                  ctl_flush,
    output logic                  stat_busy,
    output logic                  stat_frame_wrap,
    output logic [15:0]           stat_retries
);

    localparam logic [RWD_W-1:0]    BURST_LEN_C = RWD_W'(BURST_LEN);
    localparam logic [ADDR_WIDTH:0] FRAME_C     = (ADDR_WIDTH+1)'(FRAME_WORDS);

    drain_state_e          state_r, state_s;
    logic [RWD_W-1:0]      len_r, len_s;
    logic [RWD_W-1:0]      pcnt_r, pcnt_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_s;
    logic [15:0]           retries_r, retries_s;
    logic [RWD_W-1:0]      rwd_words_r, rwd_words_s;
    logic [ADDR_WIDTH:0]   sum_s;
    logic                  wrap_s;
    logic                  pop_s;
    logic                  m_valid_r;
    logic [RWD_W-1:0]      m_len_r;
    logic                  rwd_stb_r;
    logic                  busy_r;
    logic                  wrap_r;

    // Next-state, pop and bookkeeping decode
    always_comb begin
        state_s     = state_r;
        len_s       = len_r;
        pcnt_s      = pcnt_r;
        addr_s      = addr_r;
        retries_s   = retries_r;
        rwd_words_s = rwd_words_r;
        wrap_s      = 1'b0;
        pop_s       = 1'b0;
        sum_s       = {1'b0, addr_r} + (ADDR_WIDTH+1)'(len_r);
        case (state_r)
            ST_IDLE: begin
                if (ctl_run && !f_aempty) begin
                    state_s = ST_CMD;
                    len_s   = BURST_LEN_C;
                end else if (ctl_run && ctl_flush && !f_empty) begin
                    state_s = ST_CMD;
                    len_s   = RWD_W'(1);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (m_ready) begin
                    state_s = ST_DATA;
                    pcnt_s  = {RWD_W{1'b0}};
                end else begin
                    state_s = ST_CMD;
                end
            end
            ST_DATA: begin
                pop_s  = m_wnext;
                pcnt_s = pcnt_r + RWD_W'(m_wnext);
                // The pop of this same cycle is already counted in pcnt_s
                if (m_abort) begin
                    state_s     = ST_RWD;
                    rwd_words_s = pcnt_s;
                    retries_s   = sat_inc16(retries_r);
                end else if (pcnt_s == len_r) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_WAIT: begin
                if (m_abort) begin
                    state_s     = ST_RWD;
                    rwd_words_s = pcnt_r;
                    retries_s   = sat_inc16(retries_r);
                end else if (m_done) begin
                    state_s = ST_IDLE;
                    if (sum_s >= FRAME_C) begin
                        addr_s = {ADDR_WIDTH{1'b0}};
                        wrap_s = 1'b1;
                    end else begin
                        addr_s = sum_s[ADDR_WIDTH-1:0];
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RWD: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters, address and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            len_r       <= {RWD_W{1'b0}};
            pcnt_r      <= {RWD_W{1'b0}};
            addr_r      <= {ADDR_WIDTH{1'b0}};
            retries_r   <= 16'd0;
            rwd_words_r <= {RWD_W{1'b0}};
            m_valid_r   <= 1'b0;
            m_len_r     <= {RWD_W{1'b0}};
            rwd_stb_r   <= 1'b0;
            busy_r      <= 1'b0;
            wrap_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            len_r       <= len_s;
            pcnt_r      <= pcnt_s;
            addr_r      <= addr_s;
            retries_r   <= retries_s;
            rwd_words_r <= rwd_words_s;
            m_valid_r   <= (state_s == ST_CMD);
            rwd_stb_r   <= (state_s == ST_RWD) && (rwd_words_s != {RWD_W{1'b0}});
            busy_r      <= (state_s != ST_IDLE);
            wrap_r      <= wrap_s;
            if (state_s == ST_CMD) begin
                m_len_r <= len_s - RWD_W'(1);
            end else begin
                m_len_r <= m_len_r;
            end
        end
    end

    assign f_ena           = pop_s;
    assign m_wdata         = f_data;
    assign f_rwd_words     = rwd_words_r;
    assign f_rwd_stb       = rwd_stb_r;
    assign m_addr          = addr_r;
    assign m_len           = m_len_r;
    assign m_valid         = m_valid_r;
    assign stat_busy       = busy_r;
    assign stat_frame_wrap = wrap_r;
    assign stat_retries    = retries_r;

endmodule

// File: tb/tb_vid_pix_drain.sv
// Directed bench for vid_pix_drain: a behavioural rewindable FIFO feeds the DUT
// while a table of bursts drives the memory handshake and checks each outcome.
module tb_vid_pix_drain;
    import vid_pix_pkg::*;

    localparam int BL = 16;
    localparam int AW = 24;
    localparam int FW = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   f_data;
    logic          f_ena, f_aempty, f_empty;
    logic [4:0]    f_rwd_words;
    logic          f_rwd_stb;
    logic [AW-1:0] m_addr;
    logic [4:0]    m_len;
    logic          m_valid, m_ready;
    logic [31:0]   m_wdata;
    logic          m_wnext, m_done, m_abort;
    logic          ctl_run, ctl_flush;
    logic          stat_busy, stat_frame_wrap;
    logic [15:0]   stat_retries;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vid_pix_drain #(.BURST_LEN(BL), .ADDR_WIDTH(AW), .FRAME_WORDS(FW)) dut (
        .clk(clk), .rst_n(rst_n), .f_data(f_data), .f_ena(f_ena),
        .f_aempty(f_aempty), .f_empty(f_empty), .f_rwd_words(f_rwd_words),
        .f_rwd_stb(f_rwd_stb), .m_addr(m_addr), .m_len(m_len), .m_valid(m_valid),
        .m_ready(m_ready), .m_wdata(m_wdata), .m_wnext(m_wnext), .m_done(m_done),
        .m_abort(m_abort), .ctl_run(ctl_run), .ctl_flush(ctl_flush),
        .stat_busy(stat_busy), .stat_frame_wrap(stat_frame_wrap),
        .stat_retries(stat_retries)
    );

    // FIFO model: word i holds value i; pops advance, rewinds step back.
    logic [31:0] mem [0:255];
    logic [7:0]  rd_ptr, wr_ptr, cnt;
    logic        underflow = 1'b0;
    int          rwd_seen = 0;

    assign cnt      = wr_ptr - rd_ptr;
    assign f_empty  = (cnt == 8'd0);
    assign f_aempty = (cnt < 8'd16);
    assign f_data   = mem[rd_ptr];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 8'd0;
        end else if (f_rwd_stb) begin
            rd_ptr <= rd_ptr - {3'd0, f_rwd_words};
        end else if (f_ena) begin
            rd_ptr <= rd_ptr + 8'd1;
        end
    end

    always @(posedge clk) begin
        if (f_ena && f_empty) underflow <= 1'b1;
        if (f_rwd_stb) rwd_seen <= rwd_seen + 1;
    end

    typedef struct {
        int          mode;    // 0 done, 1 abort in DATA, 2 abort in WAIT, 3 done+abort
        int          beats;
        logic [23:0] addr;
        logic [4:0]  len;
        logic [31:0] data;
        logic [4:0]  rwd;
        logic [15:0] retries;
        logic        wrap;
        logic        flush;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_cmd();
        int n = 0;
        while (!m_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_valid", 32'(m_valid), 32'd1);
    endtask

    task automatic idle_check(input string nm, input int cycles);
        int seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (m_valid) seen++;
        end
        chk(nm, 32'(seen), 32'd0);
    endtask

    task automatic run_burst(input vec_t v);
        ctl_flush = v.flush;
        wait_cmd();
        chk("cmd_addr", 32'(m_addr), 32'(v.addr));
        chk("cmd_len", 32'(m_len), 32'(v.len));
        @(negedge clk);
        chk("cmd_hold", 32'({m_valid, m_addr}), 32'({1'b1, v.addr}));
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        chk("cmd_drop", 32'(m_valid), 32'd0);
        for (int i = 0; i < v.beats; i++) begin
            m_wnext = 1'b1;
            #1;
            chk("pop_ena", 32'(f_ena), 32'd1);
            chk("wdata", m_wdata, v.data + 32'(i));
            @(negedge clk);
        end
        m_wnext = 1'b0;
        if (v.mode == 0) begin
            m_wnext = 1'b1;
            #1;
            chk("wait_no_pop", 32'(f_ena), 32'd0);
            m_wnext = 1'b0;
            m_done  = 1'b1;
            @(negedge clk);
            m_done = 1'b0;
            chk("frame_wrap", 32'(stat_frame_wrap), 32'(v.wrap));
        end else begin
            m_abort = 1'b1;
            m_done  = (v.mode == 3);
            @(negedge clk);
            m_abort = 1'b0;
            m_done  = 1'b0;
            chk("rwd_stb", 32'(f_rwd_stb), 32'd1);
            chk("rwd_words", 32'(f_rwd_words), 32'(v.rwd));
            @(negedge clk);
            chk("rwd_stb_once", 32'(f_rwd_stb), 32'd0);
        end
        chk("retries", 32'(stat_retries), 32'(v.retries));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int rwd_before;
        for (int i = 0; i < 256; i++) mem[i] = 32'(i);
        //           mode beats addr    len    data     rwd    retries wrap flush
        vecs[0]  = '{0, 16, 24'd0,  5'd15, 32'd0,   5'd0,  16'd0, 1'b0, 1'b0};
        vecs[1]  = '{1,  7, 24'd16, 5'd15, 32'd16,  5'd7,  16'd1, 1'b0, 1'b0};
        vecs[2]  = '{0, 16, 24'd16, 5'd15, 32'd16,  5'd0,  16'd1, 1'b0, 1'b0};
        vecs[3]  = '{2, 16, 24'd32, 5'd15, 32'd32,  5'd16, 16'd2, 1'b0, 1'b0};
        vecs[4]  = '{3, 16, 24'd32, 5'd15, 32'd32,  5'd16, 16'd3, 1'b0, 1'b0};
        vecs[5]  = '{0, 16, 24'd32, 5'd15, 32'd32,  5'd0,  16'd3, 1'b0, 1'b0};
        vecs[6]  = '{0, 16, 24'd48, 5'd15, 32'd48,  5'd0,  16'd3, 1'b1, 1'b0};
        vecs[7]  = '{0, 16, 24'd0,  5'd15, 32'd64,  5'd0,  16'd3, 1'b0, 1'b0};
        vecs[8]  = '{0, 16, 24'd32, 5'd15, 32'd96,  5'd0,  16'd3, 1'b0, 1'b0};
        vecs[9]  = '{0,  1, 24'd48, 5'd0,  32'd112, 5'd0,  16'd3, 1'b0, 1'b1};
        vecs[10] = '{0,  1, 24'd49, 5'd0,  32'd113, 5'd0,  16'd3, 1'b0, 1'b1};
        vecs[11] = '{0,  1, 24'd50, 5'd0,  32'd114, 5'd0,  16'd3, 1'b0, 1'b1};

        rst_n = 1'b0; wr_ptr = 8'd0;
        m_ready = 1'b0; m_wnext = 1'b0; m_done = 1'b0; m_abort = 1'b0;
        ctl_run = 1'b0; ctl_flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", 32'({f_ena, f_rwd_stb, m_valid, stat_busy, stat_frame_wrap}), 32'd0);
        chk("rst_values", 32'({f_rwd_words, m_len, stat_retries}), 32'd0);
        chk("rst_addr", 32'(m_addr), 32'd0);

        rst_n = 1'b1; wr_ptr = 8'd115; ctl_run = 1'b1;
        for (int i = 0; i < 8; i++) run_burst(vecs[i]);

        // Run dropped mid-burst: burst completes, nothing follows despite 19 words.
        wait_cmd();
        chk("runoff_addr", 32'(m_addr), 32'd16);
        m_ready = 1'b1; @(negedge clk); m_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 4) ctl_run = 1'b0;
            m_wnext = 1'b1; #1;
            chk("runoff_wdata", m_wdata, 32'd80 + 32'(i));
            @(negedge clk);
        end
        m_wnext = 1'b0; m_done = 1'b1; @(negedge clk); m_done = 1'b0;
        idle_check("runoff_no_cmd", 20);
        chk("runoff_idle", 32'(stat_busy), 32'd0);
        ctl_run = 1'b1;

        run_burst(vecs[8]);
        idle_check("aempty_no_cmd", 10);
        for (int i = 9; i < 12; i++) run_burst(vecs[i]);
        idle_check("flush_done_no_cmd", 10);
        chk("flush_empty", 32'(f_empty), 32'd1);
        chk("flush_idle", 32'(stat_busy), 32'd0);

        // Reset while in DATA with a pop in progress.
        ctl_flush = 1'b0;
        wr_ptr = wr_ptr + 8'd16;
        wait_cmd();
        chk("pre_rst_addr", 32'(m_addr), 32'd51);
        m_ready = 1'b1; @(negedge clk); m_ready = 1'b0;
        repeat (5) begin
            m_wnext = 1'b1;
            @(negedge clk);
        end
        rwd_before = rwd_seen;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_outputs", 32'({f_ena, f_rwd_stb, m_valid, stat_busy, stat_frame_wrap}), 32'd0);
        chk("mid_rst_values", 32'({f_rwd_words, m_len, stat_retries}), 32'd0);
        chk("mid_rst_addr", 32'(m_addr), 32'd0);
        m_wnext = 1'b0;
        wr_ptr = 8'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (m_valid || f_rwd_stb) seen++;
        end
        chk("post_rst_quiet", 32'(seen), 32'd0);
        chk("no_rwd_on_reset", 32'(rwd_seen), 32'(rwd_before));
        chk("no_underflow", 32'(underflow), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
